// File: rtl/ifu_fb_ctl.sv
// Fetch buffer: queues F2 I-cache hit groups, presents the oldest two to
// the aligner and reports per-cycle consumption back to fetch control.
// Ports: clk/rst; F2 req/hit/addr/data in; flush; aln_consume in;
// fb_valid/data0/data1/pc0/pc1 out; consume1/2, full, empty, overflow out.
module ifu_fb_ctl #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifc_fetch_req_f2,
  input  logic              ic_hit_f2,
  input  logic [30:0]       ifc_fetch_addr_f2,
  input  logic [DATA_W-1:0] ic_rd_data_f2,
  input  logic              exu_flush_final,
  input  logic [1:0]        aln_consume,
  output logic [1:0]        fb_valid,
  output logic [DATA_W-1:0] fb_data0,
  output logic [DATA_W-1:0] fb_data1,
  output logic [30:0]       fb_pc0,
  output logic [30:0]       fb_pc1,
  output logic              ifu_fb_consume1,
  output logic              ifu_fb_consume2,
  output logic              fb_full,
  output logic              fb_empty,
  output logic              fb_overflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [30:0]       pc_q   [DEPTH];

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr1;
  logic [CW-1:0] count;

  logic       wr_en;
  logic       wr_ok;
  logic       ovf_set;
  logic [1:0] req_n;
  logic [1:0] avail;
  logic [1:0] granted;

  assign wr_en = ifc_fetch_req_f2 & ic_hit_f2
               & ~exu_flush_final;

  // 2'b10 is illegal and requests nothing
  always_comb begin
    req_n = 2'd0;
    unique case (aln_consume)
      2'b01:   req_n = 2'd1;
      2'b11:   req_n = 2'd2;
      default: req_n = 2'd0;
    endcase
  end

  always_comb begin
    avail = 2'd2;
    if (count < CW'(2))
      avail = count[1:0];
  end

  always_comb begin
    granted = (req_n < avail) ? req_n : avail;
    if (exu_flush_final || rst)
      granted = 2'd0;
  end

  assign fb_full  = (count == CW'(DEPTH));
  assign fb_empty = (count == '0);

  // When full, a write only fits if a slot frees in the same cycle
  assign wr_ok   = wr_en & (~fb_full | (granted != 2'd0));
  assign ovf_set = wr_en & fb_full & (granted == 2'd0);

  assign ifu_fb_consume1 = (granted == 2'd1);
  assign ifu_fb_consume2 = (granted == 2'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (exu_flush_final) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + AW'(granted);
      if (wr_ok)
        wr_ptr <= wr_ptr + AW'(1);
      count <= count + CW'(wr_ok) - CW'(granted);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      fb_overflow_err <= 1'b0;
    else if (ovf_set)
      fb_overflow_err <= 1'b1;
  end

  // Entry storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_ok && !rst) begin
      data_q[wr_ptr] <= ic_rd_data_f2;
      pc_q[wr_ptr]   <= ifc_fetch_addr_f2;
    end
  end

  assign rd_ptr1 = rd_ptr + AW'(1);

  assign fb_valid[0] = (count >= CW'(1));
  assign fb_valid[1] = (count >= CW'(2));

  assign fb_data0 = data_q[rd_ptr];
  assign fb_data1 = data_q[rd_ptr1];
  assign fb_pc0   = pc_q[rd_ptr];
  assign fb_pc1   = pc_q[rd_ptr1];

endmodule

// File: tb/tb_ifu_fb_ctl.sv
// Directed testbench for ifu_fb_ctl.
// Each task drives one scenario and checks outputs inline.
module tb_ifu_fb_ctl;

  logic        clk;
  logic        rst;
  logic        req;
  logic        hit;
  logic [30:0] addr;
  logic [63:0] rdata;
  logic        flush;
  logic [1:0]  cons;
  logic [1:0]  fb_valid;
  logic [63:0] fb_data0;
  logic [63:0] fb_data1;
  logic [30:0] fb_pc0;
  logic [30:0] fb_pc1;
  logic        c1;
  logic        c2;
  logic        fb_full;
  logic        fb_empty;
  logic        ovf;

  int vec;
  int err;

  ifu_fb_ctl #(.DEPTH(4), .DATA_W(64)) dut (
    .clk               (clk),
    .rst               (rst),
    .ifc_fetch_req_f2  (req),
    .ic_hit_f2         (hit),
    .ifc_fetch_addr_f2 (addr),
    .ic_rd_data_f2     (rdata),
    .exu_flush_final   (flush),
    .aln_consume       (cons),
    .fb_valid          (fb_valid),
    .fb_data0          (fb_data0),
    .fb_data1          (fb_data1),
    .fb_pc0            (fb_pc0),
    .fb_pc1            (fb_pc1),
    .ifu_fb_consume1   (c1),
    .ifu_fb_consume2   (c2),
    .fb_full           (fb_full),
    .fb_empty          (fb_empty),
    .fb_overflow_err   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // inputs change 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req   = 1'b0;
    hit   = 1'b0;
    flush = 1'b0;
    cons  = 2'b00;
  endtask

  task automatic set_wr(input logic [30:0] pc);
    req   = 1'b1;
    hit   = 1'b1;
    addr  = pc;
    rdata = {pc, 33'h1_5A5A_5A5A};
  endtask

  task automatic push(input logic [30:0] pc);
    set_wr(pc);
    tick();
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vec++;
    if (fb_valid !== 2'b00) begin
      err++;
      $display("FAIL reset_valid got %b exp 00", fb_valid);
    end
    vec++;
    if (fb_empty !== 1'b1 || fb_full !== 1'b0) begin
      err++;
      $display("FAIL reset_flags got e%b f%b exp e1 f0",
               fb_empty, fb_full);
    end
    vec++;
    if (c1 !== 1'b0 || c2 !== 1'b0 || ovf !== 1'b0) begin
      err++;
      $display("FAIL reset_outs got c1%b c2%b ovf%b exp 000",
               c1, c2, ovf);
    end
  endtask

  task automatic test_write_gating();
    set_wr(31'h50);
    hit = 1'b0;
    tick();
    set_wr(31'h54);
    req = 1'b0;
    tick();
    idle();
    #1;
    vec++;
    if (fb_empty !== 1'b1 || fb_valid !== 2'b00) begin
      err++;
      $display("FAIL gated_write got e%b v%b exp e1 v00",
               fb_empty, fb_valid);
    end
  endtask

  task automatic test_basic_write();
    do_reset();
    push(31'h100);
    vec++;
    if (fb_valid !== 2'b01 || fb_pc0 !== 31'h100) begin
      err++;
      $display("FAIL wr_latency got v%b pc0 %h exp v01 pc0 100",
               fb_valid, fb_pc0);
    end
    push(31'h104);
    push(31'h108);
    #1;
    vec++;
    if (fb_valid !== 2'b11) begin
      err++;
      $display("FAIL basic_valid got %b exp 11", fb_valid);
    end
    vec++;
    if (fb_pc0 !== 31'h100 || fb_pc1 !== 31'h104) begin
      err++;
      $display("FAIL basic_pc got %h %h exp 100 104",
               fb_pc0, fb_pc1);
    end
    vec++;
    if (fb_data0 !== {31'h100, 33'h1_5A5A_5A5A}) begin
      err++;
      $display("FAIL basic_data0 got %h", fb_data0);
    end
    vec++;
    if (fb_full !== 1'b0 || fb_empty !== 1'b0) begin
      err++;
      $display("FAIL basic_flags got f%b e%b exp f0 e0",
               fb_full, fb_empty);
    end
  endtask

  task automatic test_consume2_wrap();
    logic [30:0] hp;
    push(31'h10C);
    #1;
    vec++;
    if (fb_full !== 1'b1) begin
      err++;
      $display("FAIL full_at_4 got %b exp 1", fb_full);
    end
    set_wr(31'h110);
    cons = 2'b11;
    #1;
    vec++;
    if (c2 !== 1'b1 || c1 !== 1'b0) begin
      err++;
      $display("FAIL full_cons2 got c1%b c2%b exp c1 0 c2 1",
               c1, c2);
    end
    tick();
    idle();
    #1;
    vec++;
    if (fb_pc0 !== 31'h108 || fb_pc1 !== 31'h10C ||
        fb_valid !== 2'b11 || fb_full !== 1'b0) begin
      err++;
      $display("FAIL after_cons2 got %h %h v%b f%b exp 108 10c v11 f0",
               fb_pc0, fb_pc1, fb_valid, fb_full);
    end
    // write + consume-1 steady state; count stays at 3
    for (int i = 0; i < 8; i++) begin
      hp = 31'h108 + 31'(4 * i);
      set_wr(31'h114 + 31'(4 * i));
      cons = 2'b01;
      #1;
      vec++;
      if (c1 !== 1'b1 || c2 !== 1'b0 || fb_pc0 !== hp) begin
        err++;
        $display("FAIL wrap_%0d got c1%b c2%b pc0 %h exp 1 0 %h",
                 i, c1, c2, fb_pc0, hp);
      end
      tick();
    end
    idle();
    #1;
    vec++;
    if (fb_pc0 !== 31'h128 || fb_pc1 !== 31'h12C ||
        fb_valid !== 2'b11 || fb_full !== 1'b0) begin
      err++;
      $display("FAIL wrap_end got %h %h v%b f%b exp 128 12c v11 f0",
               fb_pc0, fb_pc1, fb_valid, fb_full);
    end
  endtask

  task automatic test_partial_grant();
    cons = 2'b11;
    tick();
    idle();
    #1;
    vec++;
    if (fb_valid !== 2'b01 || fb_pc0 !== 31'h130) begin
      err++;
      $display("FAIL one_left got v%b pc0 %h exp v01 130",
               fb_valid, fb_pc0);
    end
    cons = 2'b11;
    #1;
    vec++;
    if (c1 !== 1'b1 || c2 !== 1'b0) begin
      err++;
      $display("FAIL partial got c1%b c2%b exp c1 1 c2 0", c1, c2);
    end
    tick();
    idle();
    #1;
    vec++;
    if (fb_empty !== 1'b1 || fb_valid !== 2'b00) begin
      err++;
      $display("FAIL drained got e%b v%b exp e1 v00",
               fb_empty, fb_valid);
    end
    cons = 2'b11;
    #1;
    vec++;
    if (c1 !== 1'b0 || c2 !== 1'b0) begin
      err++;
      $display("FAIL empty_cons got c1%b c2%b exp 00", c1, c2);
    end
    idle();
  endtask

  task automatic test_overflow();
    push(31'h200);
    push(31'h204);
    push(31'h208);
    push(31'h20C);
    set_wr(31'h300);
    tick();
    idle();
    #1;
    vec++;
    if (ovf !== 1'b1 || fb_full !== 1'b1) begin
      err++;
      $display("FAIL ovf_set got ovf%b f%b exp 1 1", ovf, fb_full);
    end
    vec++;
    if (fb_pc0 !== 31'h200 || fb_pc1 !== 31'h204) begin
      err++;
      $display("FAIL ovf_keep got %h %h exp 200 204",
               fb_pc0, fb_pc1);
    end
    cons = 2'b11;
    tick();
    idle();
    #1;
    vec++;
    if (fb_pc0 !== 31'h208 || fb_pc1 !== 31'h20C ||
        fb_valid !== 2'b11) begin
      err++;
      $display("FAIL ovf_tail got %h %h v%b exp 208 20c v11",
               fb_pc0, fb_pc1, fb_valid);
    end
    flush = 1'b1;
    tick();
    idle();
    #1;
    vec++;
    if (ovf !== 1'b1 || fb_empty !== 1'b1) begin
      err++;
      $display("FAIL ovf_flush got ovf%b e%b exp 1 1", ovf, fb_empty);
    end
    do_reset();
    #1;
    vec++;
    if (ovf !== 1'b0) begin
      err++;
      $display("FAIL ovf_rst got %b exp 0", ovf);
    end
  endtask

  task automatic test_flush();
    push(31'h400);
    push(31'h404);
    push(31'h408);
    set_wr(31'h500);
    flush = 1'b1;
    cons  = 2'b01;
    #1;
    vec++;
    if (c1 !== 1'b0 || c2 !== 1'b0) begin
      err++;
      $display("FAIL flush_cons got c1%b c2%b exp 00", c1, c2);
    end
    tick();
    idle();
    #1;
    vec++;
    if (fb_empty !== 1'b1 || fb_valid !== 2'b00) begin
      err++;
      $display("FAIL flush_empty got e%b v%b exp e1 v00",
               fb_empty, fb_valid);
    end
    push(31'h600);
    push(31'h604);
    #1;
    vec++;
    if (fb_valid !== 2'b11 || fb_pc0 !== 31'h600 ||
        fb_pc1 !== 31'h604) begin
      err++;
      $display("FAIL post_flush got v%b %h %h exp v11 600 604",
               fb_valid, fb_pc0, fb_pc1);
    end
  endtask

  task automatic test_reset_mid();
    set_wr(31'h700);
    cons = 2'b11;
    rst  = 1'b1;
    #1;
    vec++;
    if (c1 !== 1'b0 || c2 !== 1'b0) begin
      err++;
      $display("FAIL rst_cons got c1%b c2%b exp 00", c1, c2);
    end
    tick();
    rst = 1'b0;
    idle();
    #1;
    vec++;
    if (fb_empty !== 1'b1 || fb_valid !== 2'b00) begin
      err++;
      $display("FAIL rst_mid got e%b v%b exp e1 v00",
               fb_empty, fb_valid);
    end
  endtask

  initial begin
    vec   = 0;
    err   = 0;
    rst   = 1'b0;
    addr  = '0;
    rdata = '0;
    idle();
    #2;
    test_reset();
    test_write_gating();
    test_basic_write();
    test_consume2_wrap();
    test_partial_grant();
    test_overflow();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/ifu_fb_ctl.md
Name: ifu_fb_ctl

Overview:
- Fetch buffer that captures fetch groups returned in F2 on an I-cache hit.
- Holds up to DEPTH groups in FIFO order and presents the oldest two to the aligner.
- Reports per-cycle consumption as ifu_fb_consume1/ifu_fb_consume2 back to fetch control, which uses them for fetch-buffer mass balancing and throttling.
- Sits directly downstream of the fetch control / I-cache F2 stage.

Parameters:
- DEPTH, 4: number of fetch-group entries; power of 2, at least 2.
- DATA_W, 64: bits of instruction data per fetch group.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-high.
- ifc_fetch_req_f2  in  1  F2 fetch valid.
- ic_hit_f2  in  1  I-cache hit for the F2 fetch.
- ifc_fetch_addr_f2  in  31  F2 fetch address [31:1].
- ic_rd_data_f2  in  DATA_W  F2 fetch data.
- exu_flush_final  in  1  pipeline flush.
- aln_consume  in  2  aligner consume request: 00 none, 01 one entry, 11 two entries; 10 is illegal and treated as 00.
- fb_valid  out  2  [0] head entry valid, [1] head+1 entry valid.
- fb_data0  out  DATA_W  head entry data.
- fb_data1  out  DATA_W  head+1 entry data.
- fb_pc0  out  31  head entry address.
- fb_pc1  out  31  head+1 entry address.
- ifu_fb_consume1  out  1  exactly one entry consumed this cycle.
- ifu_fb_consume2  out  1  two entries consumed this cycle.
- fb_full  out  1  count == DEPTH.
- fb_empty  out  1  count == 0.
- fb_overflow_err  out  1  sticky: a write arrived while full with no consume in the same cycle.

Behaviour:
- Storage:
  - DEPTH entries of {data, pc}.
  - rd_ptr and wr_ptr are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Reset (synchronous, rst=1 at a clk edge):
  - rd_ptr=0, wr_ptr=0, count=0, fb_overflow_err=0.
  - Outputs after reset: fb_valid=00, fb_empty=1, fb_full=0, consume outputs 0.
  - Entry contents are not reset.
  - Reset mid-operation discards all entries, including any write in that cycle.
- Write:
  - wr_en = ifc_fetch_req_f2 & ic_hit_f2 & ~exu_flush_final.
  - The entry is stored at wr_ptr on the clk edge.
  - Visible on the outputs the next cycle: 1-cycle write-to-read latency, no bypass.
- Consume:
  - num_avail = min(count, 2).
  - Granted count = min(requested, num_avail).
  - ifu_fb_consume1 = (granted == 1); ifu_fb_consume2 = (granted == 2).
  - Both are combinational from aln_consume and registered count, so fetch control sees them in the same cycle.
  - Both are forced to 0 during exu_flush_final and rst.
  - rd_ptr advances by the granted count.
- Simultaneous write and consume:
  - Both happen; count_next = count + wr_en - granted.
  - Write while full with granted >= 1 is legal: the freed slot is reused.
  - Write while full with granted == 0: the write is dropped, fb_overflow_err sets, and pointers/count are unchanged. This is a protocol violation that fetch control prevents via its full throttle.
- Flush:
  - exu_flush_final=1: next state is rd_ptr=wr_ptr=0, count=0.
  - Any concurrent write and consume are discarded.
  - fb_overflow_err is not cleared; only rst clears it.
- Read outputs:
  - fb_valid[0] = count >= 1; fb_valid[1] = count >= 2.
  - fb_data0/fb_pc0 come from entry rd_ptr; fb_data1/fb_pc1 come from entry (rd_ptr+1) mod DEPTH.
  - Output data is don't-care when the corresponding valid bit is 0.
- Flags: fb_full = (count == DEPTH); fb_empty = (count == 0). Both are registered-state derived.
- Pointer wrap: head+1 indexing and both pointers wrap across entry DEPTH-1 -> 0 with no bubble.

Test Plan:
- Reset then 3 hit writes (pc 0x100, 0x104, 0x108), no consume -> fb_valid=11, fb_pc0=0x100, fb_pc1=0x104; count 3, fb_full=0.
- Write with ic_hit_f2=0 or ifc_fetch_req_f2=0 -> no entry stored; fb_empty stays 1.
- Fill to 4, then aln_consume=11 with a write of pc 0x110 in the same cycle:
  - consume2=1, consume1=0 that cycle.
  - Next cycle count=3, fb_pc0=0x108, fb_pc1=0x10C.
  - Continue 8 cycles of write + consume-1 -> pointers wrap, FIFO order preserved.
- count=1 with aln_consume=11 -> consume1=1, consume2=0; count 0; fb_empty=1 next cycle.
- Full, write with aln_consume=00 -> fb_overflow_err=1 next cycle, count stays 4, contents unchanged. Subsequent flush leaves the error at 1; rst clears it.
- count=3, exu_flush_final with a concurrent hit write and aln_consume=01:
  - consume outputs 0 that cycle.
  - Next cycle fb_empty=1, fb_valid=00.
  - Next write lands in entry 0 with 1-cycle latency.
